// File: rtl/pwm_capture.sv
// Multi-channel PWM pulse capture: measures high time and period of each input
// line in clk cycles and exposes the results on a registered cs/addr read port.
module pwm_capture #(
  parameter int SIGNAL_BIT_WIDTH  = 15,
  parameter int ADDRESS_BIT_WIDTH = 3,
  parameter int PWM_SIGNAL_COUNT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PWM_SIGNAL_COUNT-1:0]  signal,
  input  logic                         cs,
  input  logic [ADDRESS_BIT_WIDTH-1:0] addr,
  output logic [SIGNAL_BIT_WIDTH-1:0]  data,
  output logic [PWM_SIGNAL_COUNT-1:0]  valid,
  output logic [PWM_SIGNAL_COUNT-1:0]  sample
);

  localparam int CH_BITS  = ADDRESS_BIT_WIDTH - 1;
  localparam int CH_SPACE = 1 << CH_BITS;
  localparam logic [SIGNAL_BIT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [SIGNAL_BIT_WIDTH-1:0] CNT_ONE = SIGNAL_BIT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [PWM_SIGNAL_COUNT-1:0] sync1_reg;
  logic [PWM_SIGNAL_COUNT-1:0] sync2_reg;
  logic [PWM_SIGNAL_COUNT-1:0] prev_reg;
  logic [PWM_SIGNAL_COUNT-1:0] armed_reg;
  logic [1:0]                  warm_reg;
  logic [PWM_SIGNAL_COUNT-1:0] rise;
  logic [PWM_SIGNAL_COUNT-1:0] fall;

  // warm_reg marks when sync2 reflects the real line; a channel is armed only
  // once it has been seen low, so a line high at reset release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      armed_reg <= '0;
      warm_reg  <= '0;
    end else begin
      sync1_reg <= signal;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      warm_reg  <= {warm_reg[0], 1'b1};
      armed_reg <= armed_reg | ({PWM_SIGNAL_COUNT{warm_reg[1]}} & ~sync2_reg);
    end
  end

  assign rise = sync2_reg & ~prev_reg;
  assign fall = ~sync2_reg & prev_reg;

  logic [SIGNAL_BIT_WIDTH-1:0] width_all  [CH_SPACE];
  logic [SIGNAL_BIT_WIDTH-1:0] period_all [CH_SPACE];

  genvar gi;
  generate
    for (gi = 0; gi < CH_SPACE; gi++) begin : g_ch
      if (gi < PWM_SIGNAL_COUNT) begin : g_live
        state_t                      state_reg;
        logic [SIGNAL_BIT_WIDTH-1:0] cnt_reg;
        logic [SIGNAL_BIT_WIDTH-1:0] pend_reg;
        logic [SIGNAL_BIT_WIDTH-1:0] width_reg;
        logic [SIGNAL_BIT_WIDTH-1:0] period_reg;
        logic                        valid_reg;
        logic                        sample_reg;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            pend_reg   <= '0;
            width_reg  <= '0;
            period_reg <= '0;
            valid_reg  <= 1'b0;
            sample_reg <= 1'b0;
          end else begin
            sample_reg <= 1'b0;
            case (state_reg)
              IDLE: begin
                cnt_reg <= '0;
                if (rise[gi] && armed_reg[gi]) begin
                  cnt_reg   <= CNT_ONE;
                  state_reg <= HIGH;
                end
              end
              HIGH: begin
                if (fall[gi]) begin
                  pend_reg  <= cnt_reg;
                  cnt_reg   <= cnt_reg + 1'b1;
                  state_reg <= LOW;
                end else if (cnt_reg == CNT_MAX) begin
                  state_reg  <= IDLE;
                  cnt_reg    <= '0;
                  valid_reg  <= 1'b0;
                  width_reg  <= '0;
                  period_reg <= '0;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                end
              end
              LOW: begin
                // Width and period commit on the same edge so a reader never
                // sees a mixed pair.
                if (rise[gi]) begin
                  period_reg <= cnt_reg;
                  width_reg  <= pend_reg;
                  valid_reg  <= 1'b1;
                  sample_reg <= 1'b1;
                  cnt_reg    <= CNT_ONE;
                  state_reg  <= HIGH;
                end else if (cnt_reg == CNT_MAX) begin
                  state_reg  <= IDLE;
                  cnt_reg    <= '0;
                  valid_reg  <= 1'b0;
                  width_reg  <= '0;
                  period_reg <= '0;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                end
              end
              default: begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
              end
            endcase
          end
        end

        assign width_all[gi]  = width_reg;
        assign period_all[gi] = period_reg;
        assign valid[gi]      = valid_reg;
        assign sample[gi]     = sample_reg;
      end else begin : g_pad
        // Unpopulated channel slots read back as zero.
        assign width_all[gi]  = '0;
        assign period_all[gi] = '0;
      end
    end
  endgenerate

  logic [CH_BITS-1:0] rd_ch;
  assign rd_ch = addr[CH_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (cs) begin
      data <= addr[CH_BITS] ? period_all[rd_ch] : width_all[rd_ch];
    end else begin
      data <= '0;
    end
  end

endmodule
